key_source_arbiter: RTL and testbench
=====================================

// Module: key_source_arbiter
// PURPOSE
//  Merges two key streams into one terminal input stream: USB keyboard keys and UART RX bytes.
//  Serves the two sources round-robin and buffers keys in a small show-ahead FIFO.
//  Every output key is tagged with its source. Sits between the keyboard/UART front ends and
//  the terminal character engine. All keys use the valid / one-cycle-ready convention.
// PARAMETERS
//  DEPTH  8  FIFO entries; power of two, >= 2
//  AW     3  FIFO address width = log2(DEPTH)
// PORTS
//  i_clk        in   1  system clock; single clock domain
//  i_rst_n      in   1  asynchronous reset, active low
//  i_usb_valid  in   1  USB key pending; held until acked
//  i_usb_key    in   8  USB key code
//  o_usb_ready  out  1  one-cycle ack: USB key taken
//  i_uart_valid in   1  UART byte pending; held until acked
//  i_uart_key   in   8  UART byte
//  o_uart_ready out  1  one-cycle ack: UART byte taken
//  i_src_en     in   2  per-source enable: [0]=USB, [1]=UART
//  o_key_valid  out  1  FIFO not empty
//  o_key        out  8  key at FIFO head (show-ahead)
//  o_key_src    out  1  source of head key: 0=USB, 1=UART
//  i_key_ready  in   1  consumer pops head when o_key_valid && i_key_ready
//  o_overflow   out  1  sticky; set when a key waits while the FIFO is full
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - outputs: o_*_ready=0, o_key_valid=0, o_key=0, o_key_src=0, o_overflow=0
//   - FIFO emptied; FSM=IDLE; priority pointer=USB
//   - mid-operation reset discards buffered keys and any pending ack
//  Eligibility: source s is eligible when i_s_valid && i_src_en[s] && count<DEPTH (registered count).
//  FSM (one grant per three cycles):
//   - IDLE: if any source eligible, pick it; both eligible -> pointer source wins; go GRANT
//   - GRANT: push {src,key} into FIFO; drive o_<src>_ready=1 for this cycle only;
//     pointer <= other source; go GAP
//   - GAP: no grant; the source drops its valid one cycle after the ack, so this cycle is
//     required to avoid double capture; go IDLE
//   - source choice is latched in IDLE; key data is sampled in GRANT (the source holds it stable)
//   - a source disabled via i_src_en while in GRANT is still pushed (grant is committed)
//  FIFO:
//   - o_key/o_key_src come straight from the head entry; latency from ack to o_key_valid = 1 cycle
//   - pop iff o_key_valid && i_key_ready; i_key_ready while empty is ignored
//   - push and pop in the same cycle: both happen, count unchanged
//   - full is judged on the registered count: a same-cycle pop does not enable a grant that cycle
//   - pointers wrap modulo DEPTH; count is AW+1 bits, 0..DEPTH
//  o_overflow: set in IDLE when any enabled source is valid and count==DEPTH; cleared only by reset.
//  No key is dropped: a blocked source simply stays un-acked.
// STRUCTURE
//  - shared package key_pkg: SRC_USB=1'b0, SRC_UART=1'b1; FSM encodings
//    ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2; KEY_W=8
//  - sub-module key_fifo (DEPTH, AW, width KEY_W+1): show-ahead synchronous FIFO with
//    push/pop/full/empty/count, async active-low reset
//  - top level holds the arbiter FSM, the priority pointer and the overflow flag
// TESTING
//  1. USB valid with key 8'h41, UART idle -> o_usb_ready high exactly one cycle;
//     next cycle o_key_valid=1, o_key=41, o_key_src=0.
//  2. Both valid from the same cycle (USB 8'h61, UART 8'h0D) after reset -> USB acked first,
//     UART three cycles later; FIFO order 61/src0, 0D/src1.
//  3. i_key_ready held 0; USB source re-asserts valid after each ack; 9 keys offered with DEPTH=8
//     -> 8 acks, 9th not acked, o_overflow=1; one pop -> 9th key acked on the next grant.
//  4. i_src_en=2'b01 with UART valid (8'h55) -> no UART ack; set i_src_en=2'b11 -> byte 55
//     accepted with src=1.
//  5. Push and pop in the same cycle with count=3 -> count stays 3; head advances in order
//     across pointer wrap (20 keys through DEPTH=8).
//  6. Assert i_rst_n=0 during GRANT with 4 keys buffered -> o_key_valid=0 and all acks 0
//     immediately; after release the first grant goes to USB.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types for the key source arbiter: source tags,
// arbiter FSM encodings and the buffered key entry.
package key_pkg;

  localparam int KEY_W = 8;

  localparam logic SRC_USB  = 1'b0;
  localparam logic SRC_UART = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic             src;
    logic [KEY_W-1:0] key;
  } key_ent_t;

endpackage

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry (zero when empty).
// Ports: clk, rst_n, push/din, pop/dout, full, empty, count (0..DEPTH).
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = KEY_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEP);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_source_arbiter.sv
// Round-robin merge of USB and UART key streams into a tagged FIFO.
// Ports: i_clk, i_rst_n, USB/UART valid/key/ready, i_src_en, key out, o_overflow.
module key_source_arbiter
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_usb_valid,
  input  logic [KEY_W-1:0] i_usb_key,
  output logic             o_usb_ready,
  input  logic             i_uart_valid,
  input  logic [KEY_W-1:0] i_uart_key,
  output logic             o_uart_ready,
  input  logic [1:0]       i_src_en,
  output logic             o_key_valid,
  output logic [KEY_W-1:0] o_key,
  output logic             o_key_src,
  input  logic             i_key_ready,
  output logic             o_overflow
);

  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

  state_t   state;
  logic     ptr;
  logic     gsrc;
  logic     pick;
  logic     usb_req;
  logic     uart_req;
  logic     usb_elig;
  logic     uart_elig;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  logic [AW:0] cnt;
  key_ent_t push_ent;
  key_ent_t head;

  assign usb_req   = i_usb_valid && i_src_en[0];
  assign uart_req  = i_uart_valid && i_src_en[1];
  assign usb_elig  = usb_req && !full;
  assign uart_elig = uart_req && !full;

  always_comb begin
    pick = SRC_USB;
    if (usb_elig && uart_elig) pick = ptr;
    else if (uart_elig)        pick = SRC_UART;
  end

  // Grant is committed once latched: push regardless of i_src_en now.
  assign push         = (state == ST_GRANT);
  assign push_ent.src = gsrc;
  assign push_ent.key = (gsrc == SRC_UART) ? i_uart_key : i_usb_key;
  assign pop          = o_key_valid && i_key_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      ptr          <= SRC_USB;
      gsrc         <= SRC_USB;
      o_usb_ready  <= 1'b0;
      o_uart_ready <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_usb_ready  <= 1'b0;
      o_uart_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if ((usb_req || uart_req) && cnt == DEP)
            o_overflow <= 1'b1;
          if (usb_elig || uart_elig) begin
            gsrc         <= pick;
            o_usb_ready  <= (pick == SRC_USB);
            o_uart_ready <= (pick == SRC_UART);
            state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          ptr   <= ~gsrc;
          state <= ST_GAP;
        end
        // Source still shows the acked key here.
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     ($bits(key_ent_t))
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  assign o_key_valid = !empty;
  assign o_key       = head.key;
  assign o_key_src   = head.src;

endmodule

// File: tb/tb_key_source_arbiter.sv
// Directed bench for key_source_arbiter: vector table plus
// hand sequences for fill/overflow, enable, wrap and reset.
module tb_key_source_arbiter;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_usb_valid;
  logic [7:0] i_usb_key;
  logic       o_usb_ready;
  logic       i_uart_valid;
  logic [7:0] i_uart_key;
  logic       o_uart_ready;
  logic [1:0] i_src_en;
  logic       o_key_valid;
  logic [7:0] o_key;
  logic       o_key_src;
  logic       i_key_ready;
  logic       o_overflow;

  always #5 clk = ~clk;

  key_source_arbiter #(.DEPTH(8), .AW(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_usb_valid  (i_usb_valid),
    .i_usb_key    (i_usb_key),
    .o_usb_ready  (o_usb_ready),
    .i_uart_valid (i_uart_valid),
    .i_uart_key   (i_uart_key),
    .o_uart_ready (o_uart_ready),
    .i_src_en     (i_src_en),
    .o_key_valid  (o_key_valid),
    .o_key        (o_key),
    .o_key_src    (o_key_src),
    .i_key_ready  (i_key_ready),
    .o_overflow   (o_overflow)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int usb_acks, uart_acks;
  int usb_ack_cyc, uart_ack_cyc;
  int pops;
  bit usb_ack_d, uart_ack_d;
  logic [7:0] usb_q[$];
  logic [7:0] uart_q[$];
  logic [8:0] exp_q[$];

  typedef struct {
    logic [1:0] en;
    logic       uv;
    logic [7:0] uk;
    logic       av;
    logic [7:0] ak;
    int         eu;
    int         ea;
    logic       kv;
    logic [7:0] key;
    logic       src;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: scoreboard pop, then source protocol after the edge.
  task automatic cycle();
    if (o_key_valid && i_key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL sb_extra: got %0h expected none",
                 {o_key_src, o_key});
      end else begin
        chk("sb_head", {23'd0, o_key_src, o_key}, {23'd0, exp_q[0]});
        exp_q.pop_front();
        pops++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (usb_ack_d) begin
      chk("usb_ready_1cyc", {31'd0, o_usb_ready}, 0);
      usb_q.pop_front();
      usb_ack_d = 0;
      i_usb_valid = 1'b0;
    end else if (o_usb_ready) begin
      if (!i_usb_valid) begin
        chk("usb_spurious", {31'd0, o_usb_ready}, 0);
      end else begin
        usb_ack_d = 1;
        usb_acks++;
        usb_ack_cyc = cyc;
        exp_q.push_back({SRC_USB, i_usb_key});
      end
    end else begin
      i_usb_valid = (usb_q.size() != 0);
      if (i_usb_valid) i_usb_key = usb_q[0];
    end
    if (uart_ack_d) begin
      chk("uart_ready_1cyc", {31'd0, o_uart_ready}, 0);
      uart_q.pop_front();
      uart_ack_d = 0;
      i_uart_valid = 1'b0;
    end else if (o_uart_ready) begin
      if (!i_uart_valid) begin
        chk("uart_spurious", {31'd0, o_uart_ready}, 0);
      end else begin
        uart_ack_d = 1;
        uart_acks++;
        uart_ack_cyc = cyc;
        exp_q.push_back({SRC_UART, i_uart_key});
      end
    end else begin
      i_uart_valid = (uart_q.size() != 0);
      if (i_uart_valid) i_uart_key = uart_q[0];
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_acks(input int u, input int a,
                           input int budget, input string nm);
    int n = 0;
    while ((usb_acks < u || uart_acks < a) && n < budget) begin
      cycle();
      n++;
    end
    chk({nm, "_usb_acks"}, usb_acks, u);
    chk({nm, "_uart_acks"}, uart_acks, a);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_usb_valid = 1'b0;
    i_uart_valid = 1'b0;
    i_usb_key = 8'h00;
    i_uart_key = 8'h00;
    i_key_ready = 1'b0;
    i_src_en = 2'b11;
    usb_q.delete();
    uart_q.delete();
    exp_q.delete();
    usb_acks = 0;
    uart_acks = 0;
    usb_ack_d = 0;
    uart_ack_d = 0;
    usb_ack_cyc = 0;
    uart_ack_cyc = 0;
    pops = 0;
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 1, 8'h41, 0, 8'h00, 1, 0, 1, 8'h41, 0};
    tbl[1] = '{2'b11, 1, 8'h61, 1, 8'h0D, 1, 0, 1, 8'h61, 0};
    tbl[2] = '{2'b11, 0, 8'h00, 1, 8'h55, 0, 1, 1, 8'h55, 1};
    tbl[3] = '{2'b01, 0, 8'h00, 1, 8'h55, 0, 0, 0, 8'h00, 0};
    tbl[4] = '{2'b10, 1, 8'h41, 1, 8'h33, 0, 1, 1, 8'h33, 1};
    tbl[5] = '{2'b00, 1, 8'h41, 1, 8'h33, 0, 0, 0, 8'h00, 0};
    tbl[6] = '{2'b01, 1, 8'h7F, 1, 8'h33, 1, 0, 1, 8'h7F, 0};
    tbl[7] = '{2'b10, 1, 8'h42, 0, 8'h00, 0, 0, 0, 8'h00, 0};

    do_reset();
    chk("rst_key_valid", {31'd0, o_key_valid}, 0);
    chk("rst_key", {24'd0, o_key}, 0);
    chk("rst_key_src", {31'd0, o_key_src}, 0);
    chk("rst_usb_ready", {31'd0, o_usb_ready}, 0);
    chk("rst_uart_ready", {31'd0, o_uart_ready}, 0);
    chk("rst_overflow", {31'd0, o_overflow}, 0);

    foreach (tbl[i]) begin
      do_reset();
      i_src_en = tbl[i].en;
      if (tbl[i].uv) usb_q.push_back(tbl[i].uk);
      if (tbl[i].av) uart_q.push_back(tbl[i].ak);
      run(3);
      chk($sformatf("v%0d_usb_acks", i), usb_acks, tbl[i].eu);
      chk($sformatf("v%0d_uart_acks", i), uart_acks, tbl[i].ea);
      chk($sformatf("v%0d_kv", i), {31'd0, o_key_valid},
          {31'd0, tbl[i].kv});
      chk($sformatf("v%0d_key", i), {24'd0, o_key},
          {24'd0, tbl[i].key});
      chk($sformatf("v%0d_src", i), {31'd0, o_key_src},
          {31'd0, tbl[i].src});
      chk($sformatf("v%0d_ovf", i), {31'd0, o_overflow}, 0);
    end

    // Simultaneous requests: USB first, UART three cycles later.
    do_reset();
    usb_q.push_back(8'h61);
    uart_q.push_back(8'h0D);
    wait_acks(1, 1, 12, "both");
    chk("both_gap", uart_ack_cyc - usb_ack_cyc, 3);
    run(1);
    chk("both_h0_key", {24'd0, o_key}, 32'h61);
    chk("both_h0_src", {31'd0, o_key_src}, 0);
    i_key_ready = 1'b1;
    cycle();
    chk("both_h1_key", {24'd0, o_key}, 32'h0D);
    chk("both_h1_src", {31'd0, o_key_src}, 1);
    cycle();
    i_key_ready = 1'b0;
    chk("both_empty", {31'd0, o_key_valid}, 0);

    // Fill to DEPTH, ninth key blocked, overflow sticky.
    do_reset();
    i_src_en = 2'b01;
    for (int k = 0; k < 9; k++) usb_q.push_back(8'h80 + 8'(k));
    run(40);
    chk("fill_acks", usb_acks, 8);
    chk("fill_ovf", {31'd0, o_overflow}, 1);
    chk("fill_valid_held", {31'd0, i_usb_valid}, 1);
    i_key_ready = 1'b1;
    cycle();
    i_key_ready = 1'b0;
    wait_acks(9, 0, 8, "ninth");
    i_key_ready = 1'b1;
    run(12);
    i_key_ready = 1'b0;
    chk("fill_pops", pops, 9);
    chk("fill_drained", {31'd0, o_key_valid}, 0);
    chk("fill_ovf_sticky", {31'd0, o_overflow}, 1);

    // Disabled source is never acked until enabled.
    do_reset();
    i_src_en = 2'b01;
    uart_q.push_back(8'h55);
    run(8);
    chk("dis_uart_acks", uart_acks, 0);
    i_src_en = 2'b11;
    run(2);
    chk("en_uart_acks", uart_acks, 1);
    chk("en_key", {24'd0, o_key}, 32'h55);
    chk("en_src", {31'd0, o_key_src}, 1);

    // Push and pop in the same cycle, then 20 keys through wrap.
    do_reset();
    i_src_en = 2'b01;
    for (int k = 0; k < 3; k++) usb_q.push_back(8'h10 + 8'(k));
    wait_acks(3, 0, 20, "pre3");
    run(2);
    chk("pre3_count", {28'd0, dut.u_fifo.count}, 3);
    usb_q.push_back(8'h13);
    wait_acks(4, 0, 10, "pp");
    i_key_ready = 1'b1;
    cycle();
    i_key_ready = 1'b0;
    chk("pp_count", {28'd0, dut.u_fifo.count}, 3);
    for (int k = 4; k < 20; k++) usb_q.push_back(8'h10 + 8'(k));
    begin
      int n = 0;
      while (usb_acks < 20 && n < 300) begin
        i_key_ready = 1'($urandom_range(0, 1));
        cycle();
        n++;
      end
    end
    chk("wrap_acks", usb_acks, 20);
    i_key_ready = 1'b1;
    run(12);
    i_key_ready = 1'b0;
    chk("wrap_pops", pops, 20);
    chk("wrap_empty", {31'd0, o_key_valid}, 0);

    // Async reset in GRANT with four keys buffered.
    do_reset();
    i_src_en = 2'b01;
    for (int k = 0; k < 5; k++) usb_q.push_back(8'hC0 + 8'(k));
    wait_acks(5, 0, 30, "pre_rst");
    chk("pre_rst_count", {28'd0, dut.u_fifo.count}, 4);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_kv", {31'd0, o_key_valid}, 0);
    chk("mid_rst_usb_rdy", {31'd0, o_usb_ready}, 0);
    chk("mid_rst_uart_rdy", {31'd0, o_uart_ready}, 0);
    do_reset();
    usb_q.push_back(8'hA1);
    uart_q.push_back(8'hB1);
    begin
      int n = 0;
      while (usb_acks + uart_acks == 0 && n < 8) begin
        cycle();
        n++;
      end
    end
    chk("post_rst_usb", usb_acks, 1);
    chk("post_rst_uart", uart_acks, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
